// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Takes 8-bit words over a valid/ready handshake and sends a frame made of a start bit,
// 8 data bits (LSB or MSB first), an optional even-parity bit and 0.5/1/1.5/2 stop bits
// with programmable levels. When flow control is enabled, i_cts gates only the start of a frame.
module uart_tx #(
  parameter int CNT_W    = 32,
  parameter int IDLE_GAP = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_bit_length,
  input  logic             i_hw_flow_control_enable,
  input  logic             i_msb_first,
  input  logic [1:0]       i_stop_bit_mode,
  input  logic [1:0]       i_stop_bit_value,
  input  logic             i_parity_enable,
  input  logic             i_tx_valid,
  input  logic [7:0]       i_tx_word,
  output logic             o_tx_ready,
  input  logic             i_cts,
  output logic             o_tx,
  output logic             o_tx_busy,
  output logic             o_tx_done
);

  localparam int GAP_W = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP + 1);

  localparam logic [1:0] STOP_HALF     = 2'd0;
  localparam logic [1:0] STOP_ONE      = 2'd1;
  localparam logic [1:0] STOP_ONE_HALF = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP_2 = 3'd5
  } state_t;

  function automatic logic even_parity(input logic [7:0] word);
    return ^word;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_word;
  logic [CNT_W-1:0] r_bit_len;
  logic             r_msb;
  logic             r_par_en;
  logic [1:0]       r_stop_mode;
  logic [1:0]       r_stop_val;
  logic [GAP_W-1:0] r_gap;
  logic             r_tx;
  logic             r_done;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_dur_last;
  logic [2:0]       w_idx_next;
  logic [2:0]       w_sel;
  logic             w_done_next;
  logic             w_tx_next;
  logic             w_accept;
  logic             w_last;

  assign o_tx_ready = (r_state == S_IDLE) && (r_gap >= GAP_W'(IDLE_GAP)) &&
                      (!i_hw_flow_control_enable || i_cts);
  assign w_accept   = i_tx_valid && o_tx_ready;
  assign o_tx       = r_tx;
  assign o_tx_busy  = (r_state != S_IDLE);
  assign o_tx_done  = r_done;

  // Last counter value of the current bit: half-length stop bits use H, everything else P.
  always_comb begin
    w_dur_last = r_bit_len;
    if (((r_state == S_STOP) && (r_stop_mode == STOP_HALF)) ||
        ((r_state == S_STOP_2) && (r_stop_mode == STOP_ONE_HALF))) begin
      w_dur_last = r_bit_len >> 1;
    end else begin
      w_dur_last = r_bit_len;
    end
  end

  assign w_last = (r_cnt == w_dur_last);

  // Next-state, bit counter and done-pulse decode for the frame sequencer.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_idx_next   = r_bit_idx;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_accept) begin
          w_state_next = S_START;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_next = S_DATA;
          w_cnt_next   = '0;
          w_idx_next   = 3'd0;
        end else begin
          w_state_next = S_START;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_last) begin
          w_state_next = S_STOP;
          w_cnt_next   = '0;
        end else begin
          w_state_next = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_last) begin
          w_cnt_next = '0;
          if ((r_stop_mode == STOP_HALF) || (r_stop_mode == STOP_ONE)) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_STOP_2;
          end
        end else begin
          w_state_next = S_STOP;
        end
      end
      S_STOP_2: begin
        if (w_last) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = S_STOP_2;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_idx_next   = 3'd0;
      end
    endcase
  end

  // Line level for the state entered on the coming edge, so o_tx can be a plain register.
  always_comb begin
    w_sel     = r_msb ? (3'd7 - w_idx_next) : w_idx_next;
    w_tx_next = 1'b1;
    case (w_state_next)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_word[w_sel];
      S_PARITY: w_tx_next = even_parity(r_word);
      S_STOP:   w_tx_next = r_stop_val[0];
      S_STOP_2: w_tx_next = r_stop_val[1];
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Sequencer state, line register, inter-frame gap and frame configuration capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_word      <= 8'd0;
      r_bit_len   <= '0;
      r_msb       <= 1'b0;
      r_par_en    <= 1'b0;
      r_stop_mode <= 2'd0;
      r_stop_val  <= 2'd0;
      r_gap       <= GAP_W'(IDLE_GAP);
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_idx_next;
      r_tx      <= w_tx_next;
      r_done    <= w_done_next;
      // The done cycle already drives mark, so it counts as the first gap cycle.
      if (w_done_next) begin
        r_gap <= GAP_W'(1);
      end else if ((r_state == S_IDLE) && (r_gap < GAP_W'(IDLE_GAP))) begin
        r_gap <= r_gap + GAP_W'(1);
      end else begin
        r_gap <= r_gap;
      end
      if (w_accept) begin
        r_word      <= i_tx_word;
        r_bit_len   <= i_bit_length;
        r_msb       <= i_msb_first;
        r_par_en    <= i_parity_enable;
        r_stop_mode <= i_stop_bit_mode;
        r_stop_val  <= i_stop_bit_value;
      end else begin
        r_word      <= r_word;
        r_bit_len   <= r_bit_len;
        r_msb       <= r_msb;
        r_par_en    <= r_par_en;
        r_stop_mode <= r_stop_mode;
        r_stop_val  <= r_stop_val;
      end
    end
  end

endmodule
